// File: rtl/posit_pkg.sv
// posit_pkg
//   Shared helpers for the posit adder datapath.
//   - log2()           ceiling log2, used for regime and count widths
//   - mw() / ew()      mantissa and exponent widths for a given (N, es)
//   - norm_stage_t     payload held between add/sign recovery and normalise
//   The struct is sized for the default POSIT_N / POSIT_ES configuration.
package posit_pkg;

  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Mantissa: hidden bit at MW-1, sticky bit at 0.
  function automatic int mw(input int n, input int es);
    return n - es + 3;
  endfunction

  // Signed effective exponent: regime field + exponent field + sign.
  function automatic int ew(input int n, input int es);
    return log2(n) + es + 1;
  endfunction

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 4;
  localparam int POSIT_MW = mw(POSIT_N, POSIT_ES);
  localparam int POSIT_EW = ew(POSIT_N, POSIT_ES);

  typedef struct packed {
    logic                sign;
    logic                zero;
    logic [POSIT_MW:0]   mag;
    logic [POSIT_EW-1:0] eeff;
  } norm_stage_t;

endpackage

// File: rtl/posit_lzc.sv
// posit_lzc
//   Combinational leading-zero count of a W-bit vector.
//   Ports:
//     in_vec  [W-1:0]         vector to scan, MSB first
//     count   [log2(W):0]     number of leading zeros; W when in_vec is all zero
module posit_lzc
  import posit_pkg::*;
#(
  parameter int W  = 7,
  localparam int CW = log2(W) + 1
) (
  input  logic [W-1:0]  in_vec,
  output logic [CW-1:0] count
);

  always_comb begin
    logic found;
    found = 1'b0;
    count = CW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && in_vec[i]) begin
        found = 1'b1;
        count = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/posit_add_normalise.sv
// posit_add_normalise
//   Adds the aligned big/small mantissas from the alignment stage, recovers the
//   result sign and magnitude, then normalises (carry right-shift or leading-zero
//   left-shift) and adjusts the effective exponent. Two-stage pipeline with
//   valid/ready on both sides; in_ready is combinational from out_ready.
//   Ports:
//     clk, reset                 rising-edge clock, async active-high reset
//     in_valid / in_ready        input handshake
//     in_MB, in_MS   [MW:0]      aligned signed mantissas
//     in_Eeff        [EW-1:0]    signed effective exponent of the larger operand
//     in_s1, in_s2               operand signs
//     out_valid / out_ready      output handshake
//     out_sign                   result sign
//     out_mant       [MW-1:0]    normalised magnitude, MSB set unless out_zero
//     out_Eeff       [EW:0]      signed adjusted exponent
//     out_zero                   exact zero result
module posit_add_normalise
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int es = POSIT_ES,
  localparam int MW = mw(N, es),
  localparam int EW = ew(N, es),
  localparam int LW = log2(MW) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW:0]   in_MB,
  input  logic [MW:0]   in_MS,
  input  logic [EW-1:0] in_Eeff,
  input  logic          in_s1,
  input  logic          in_s2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [MW-1:0] out_mant,
  output logic [EW:0]   out_Eeff,
  output logic          out_zero
);

  logic        v1;
  logic        v2;
  logic        adv1;
  logic        adv2;
  norm_stage_t s1_d;
  norm_stage_t s1_q;

  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Stage 1: signed add, then sign/magnitude recovery.
  logic [MW+1:0] sum;
  logic          eff_sub;

  assign sum     = {in_MB[MW], in_MB} + {in_MS[MW], in_MS};
  assign eff_sub = in_s1 ^ in_s2;

  always_comb begin
    s1_d      = '0;
    s1_d.eeff = in_Eeff;
    if (!eff_sub) begin
      s1_d.sign = in_s1;
      s1_d.mag  = sum[MW:0];
    end else begin
      s1_d.sign = sum[MW+1];
      // Low bits of the two's complement negation; the full-width top bit is
      // never needed because mag is one bit narrower than the sum.
      s1_d.mag  = sum[MW+1] ? (~sum[MW:0] + 1'b1) : sum[MW:0];
    end
    s1_d.zero = (s1_d.mag == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2: normalise.
  logic [LW-1:0] lz;
  logic [MW-1:0] mant_d;
  logic [EW:0]   eeff_d;
  logic          sign_d;
  logic [EW:0]   eeff_ext;

  posit_lzc #(.W(MW)) u_lzc (
    .in_vec (s1_q.mag[MW-1:0]),
    .count  (lz)
  );

  assign eeff_ext = {s1_q.eeff[EW-1], s1_q.eeff};

  always_comb begin
    mant_d = '0;
    eeff_d = '0;
    sign_d = 1'b0;
    if (s1_q.mag[MW]) begin
      // Carry out: shift right by one, folding the dropped bit into sticky.
      mant_d = {s1_q.mag[MW:2], |s1_q.mag[1:0]};
      eeff_d = eeff_ext + 1'b1;
      sign_d = s1_q.sign;
    end else if (!s1_q.zero) begin
      mant_d = s1_q.mag[MW-1:0] << lz;
      eeff_d = eeff_ext - {{(EW+1-LW){1'b0}}, lz};
      sign_d = s1_q.sign;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2       <= 1'b0;
      out_sign <= 1'b0;
      out_mant <= '0;
      out_Eeff <= '0;
      out_zero <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_sign <= sign_d;
        out_mant <= mant_d;
        out_Eeff <= eeff_d;
        out_zero <= s1_q.zero;
      end
    end
  end

endmodule

// File: tb/tb_posit_add_normalise.sv
module tb_posit_add_normalise;

  typedef struct {
    bit sign;
    bit zero;
    int mant;
    int eeff;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_MB;
  logic [7:0] in_MS;
  logic [7:0] in_Eeff;
  logic       in_s1;
  logic       in_s2;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [6:0] out_mant;
  logic [8:0] out_Eeff;
  logic       out_zero;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   or_mode = 0;
  bit   t5_done;
  exp_t exp_q[$];

  posit_add_normalise dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_MB     (in_MB),
    .in_MS     (in_MS),
    .in_Eeff   (in_Eeff),
    .in_s1     (in_s1),
    .in_s2     (in_s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mant  (out_mant),
    .out_Eeff  (out_Eeff),
    .out_zero  (out_zero)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // Reference: integer add, sign/magnitude, then normalise so bit 6 is set.
  function automatic exp_t model(input logic [7:0] mb, input logic [7:0] ms,
                                 input logic [7:0] e, input bit s1, input bit s2);
    exp_t r;
    int a, b, s, mag, lz, ev;
    a  = int'($signed(mb));
    b  = int'($signed(ms));
    ev = int'($signed(e));
    s  = a + b;
    r.sign = 0; r.zero = 0; r.mant = 0; r.eeff = 0;
    if (s1 == s2) begin
      r.sign = s1;
      mag    = s & 255;
    end else begin
      r.sign = (s < 0);
      mag    = (s < 0 ? -s : s) & 255;
    end
    if (mag >= 128) begin
      r.mant = ((mag >> 2) << 1) | ((mag & 3) != 0 ? 1 : 0);
      r.eeff = ev + 1;
    end else if (mag == 0) begin
      r.zero = 1; r.sign = 0;
    end else begin
      lz = 0;
      while (mag < 64) begin
        mag = mag * 2;
        lz++;
      end
      r.mant = mag;
      r.eeff = ev - lz;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic chk_exp(input string name, input exp_t r, input int sg, input int z,
                         input int m, input int e);
    n_vec++;
    if (int'(r.sign) != sg || int'(r.zero) != z || r.mant != m || r.eeff != e) begin
      n_bad++;
      $display("FAIL %s: got s=%0d z=%0d m=%0d e=%0d expected s=%0d z=%0d m=%0d e=%0d",
               name, r.sign, r.zero, r.mant, r.eeff, sg, z, m, e);
    end
  endtask

  // Scoreboard / compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_MB, in_MS, in_Eeff, in_s1, in_s2));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got beat s=%0d m=%0d e=%0d, expected none",
                   out_sign, out_mant, $signed(out_Eeff));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_sign !== e.sign || out_zero !== e.zero || int'(out_mant) != e.mant ||
              int'($signed(out_Eeff)) != e.eeff) begin
            n_bad++;
            $display("FAIL result: got s=%0d z=%0d m=%0d e=%0d expected s=%0d z=%0d m=%0d e=%0d",
                     out_sign, out_zero, out_mant, $signed(out_Eeff),
                     e.sign, e.zero, e.mant, e.eeff);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] mb, input logic [7:0] ms, input logic [7:0] e,
                      input bit a, input bit b);
    int t;
    bit acc;
    t = 0;
    in_valid = 1; in_MB = mb; in_MS = ms; in_Eeff = e; in_s1 = a; in_s2 = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", t);
      in_valid = 0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    exp_t r;
    int base, outs;
    rst = 1; in_valid = 0; in_MB = 0; in_MS = 0; in_Eeff = 0; in_s1 = 0; in_s2 = 0;
    out_ready = 1; t5_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_mant", out_mant, 0);
    chk("rst_out_Eeff", out_Eeff, 0);
    chk("rst_out_zero", out_zero, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Pin the model with hand-computed results.
    r = model(8'h40, 8'h40, 8'd5, 0, 0); chk_exp("model_carry", r, 0, 0, 'h40, 6);
    r = model(8'h40, 8'hE0, 8'd5, 0, 1); chk_exp("model_sub", r, 0, 0, 'h40, 4);
    r = model(8'h40, 8'hC0, 8'd3, 0, 1); chk_exp("model_zero", r, 0, 1, 0, 0);
    r = model(8'hC0, 8'h20, 8'd2, 1, 0); chk_exp("model_neg", r, 1, 0, 'h40, 1);
    r = model(8'h7F, 8'h7F, 8'h7F, 0, 0); chk_exp("model_emax", r, 0, 0, 'h7F, 128);
    r = model(8'h01, 8'h00, 8'h80, 1, 1); chk_exp("model_emin", r, 1, 0, 'h40, -134);

    // Directed beats through the DUT.
    or_mode = 0;
    send(8'h40, 8'h40, 8'd5, 0, 0);
    send(8'h40, 8'hE0, 8'd5, 0, 1);
    send(8'h40, 8'hC0, 8'd3, 0, 1);
    send(8'hC0, 8'h20, 8'd2, 1, 0);
    send(8'h7F, 8'h7F, 8'h7F, 0, 0);
    send(8'h01, 8'h00, 8'h80, 1, 1);
    send(8'h80, 8'h80, 8'h10, 0, 1);
    in_valid = 0;
    drain();

    // Backpressure: pipe fills after two accepts, then drains in order.
    base = n_acc;
    or_mode = 2;
    out_ready = 0;
    fork
      begin
        send(8'h10, 8'h08, 8'd1, 0, 0);
        send(8'h20, 8'hF0, 8'd2, 0, 1);
        send(8'h30, 8'h30, 8'd3, 1, 1);
        send(8'hA0, 8'h10, 8'd4, 1, 0);
        in_valid = 0;
        t5_done = 1;
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("bp_accepts", n_acc - base, 2);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    or_mode = 0;
    out_ready = 1;
    for (int t = 0; t < 200 && !t5_done; t++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_done", t5_done, 1);
    drain();
    chk("bp_total", n_acc - base, 4);

    // Reset with two beats in flight.
    or_mode = 2;
    send(8'h11, 8'h22, 8'd7, 0, 0);
    send(8'h33, 8'h44, 8'd8, 0, 0);
    in_valid = 0;
    #3;
    rst = 1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    or_mode = 0;
    outs = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_stale", n_out - outs, 0);

    // Randomised traffic with bubbles and random backpressure.
    or_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] mb, ms, e;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(posedge clk);
        #1;
      end
      mb = 8'($urandom);
      ms = 8'($urandom);
      e  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ms = 8'(-mb);
      send(mb, ms, e, 1'($urandom), 1'($urandom));
    end
    in_valid = 0;
    or_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
